// File: rtl/cordic_sqrt_feeder.sv
// Request scheduler in front of cordic_sqrt_ex: buffers radicands in a FIFO, issues them one at
// a time through the core handshake, returns roots in order and flags requests the core drops.
module cordic_sqrt_feeder #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_vld,
   input  logic [31:0]              in_data,
   output logic                     in_rdy,
   input  logic [4:0]               cfg_iter,
   output logic                     out_vld,
   output logic [15:0]              out_data,
   input  logic                     out_rdy,
   output logic [31:0]              core_din,
   output logic [4:0]               core_iter,
   output logic                     core_start,
   output logic                     core_vldin,
   input  logic [15:0]              core_dout,
   input  logic                     core_ready,
   input  logic                     core_busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     err_timeout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned WW = $clog2(TIMEOUT) + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t state_q, state_d;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] cnt_q, cnt_d;

   logic [WW-1:0] wd_q, wd_d;
   logic [WW-1:0] wd_inc;

   logic [31:0]   core_din_q, core_din_d;
   logic [4:0]    core_iter_q, core_iter_d;
   logic          core_start_q, core_start_d;
   logic          out_vld_q, out_vld_d;
   logic [15:0]   out_data_q, out_data_d;
   logic          err_q, err_d;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          issue_go;
   logic          wd_expire;

   assign full      = (cnt_q == LVL_FULL);
   assign empty     = (cnt_q == '0);
   assign push      = in_vld && !full;
   assign pop       = (state_q == S_ISSUE);
   assign wd_inc    = wd_q + 1'b1;
   assign wd_expire = (wd_inc == WD_LAST);
   assign issue_go  = (state_q == S_IDLE) && (state_d == S_ISSUE);

   // State register and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         wd_q         <= '0;
         core_din_q   <= '0;
         core_iter_q  <= '0;
         core_start_q <= 1'b0;
         out_vld_q    <= 1'b0;
         out_data_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         wd_q         <= wd_d;
         core_din_q   <= core_din_d;
         core_iter_q  <= core_iter_d;
         core_start_q <= core_start_d;
         out_vld_q    <= out_vld_d;
         out_data_q   <= out_data_d;
         err_q        <= err_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!empty && !core_busy) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (core_ready) begin
               state_d = S_HOLD;
            end else if (wd_expire) begin
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            if (out_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      wd_d         = wd_q;
      core_din_d   = core_din_q;
      core_iter_d  = core_iter_q;
      out_vld_d    = out_vld_q;
      out_data_d   = out_data_q;
      err_d        = 1'b0;
      // start/vldin register mirrors the next state so the pulse coincides with ISSUE
      core_start_d = (state_d == S_ISSUE);

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      if (issue_go) begin
         core_din_d  = mem_q[rd_ptr_q];
         core_iter_d = cfg_iter;
      end

      unique case (state_q)
         S_ISSUE: begin
            wd_d = '0;
         end
         S_WAIT: begin
            if (core_ready) begin
               out_vld_d  = 1'b1;
               out_data_d = core_dout;
            end else begin
               wd_d  = wd_inc;
               err_d = wd_expire;
            end
         end
         S_HOLD: begin
            if (out_rdy) begin
               out_vld_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign in_rdy      = !full;
   assign fifo_level  = cnt_q;
   assign core_din    = core_din_q;
   assign core_iter   = core_iter_q;
   assign core_start  = core_start_q;
   assign core_vldin  = core_start_q;
   assign out_vld     = out_vld_q;
   assign out_data    = out_data_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_cordic_sqrt_feeder.sv
// Bench for cordic_sqrt_feeder: behavioural sqrt core, level model and an in-order result scoreboard.
module tb_cordic_sqrt_feeder;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 64;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_vld;
   logic [31:0]            in_data;
   logic                   in_rdy;
   logic [4:0]             cfg_iter;
   logic                   out_vld;
   logic [15:0]            out_data;
   logic                   out_rdy;
   logic [31:0]            core_din;
   logic [4:0]             core_iter;
   logic                   core_start;
   logic                   core_vldin;
   logic [15:0]            core_dout;
   logic                   core_ready;
   logic                   core_busy;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   err_timeout;

   logic        model_ready = 1'b0;
   logic [15:0] model_dout  = '0;
   logic        stray_ready = 1'b0;
   logic [15:0] stray_dout  = '0;

   assign core_ready = model_ready | stray_ready;
   assign core_dout  = stray_ready ? stray_dout : model_dout;

   always #5 clk = ~clk;

   cordic_sqrt_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy), .cfg_iter(cfg_iter),
      .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
      .core_din(core_din), .core_iter(core_iter), .core_start(core_start), .core_vldin(core_vldin),
      .core_dout(core_dout), .core_ready(core_ready), .core_busy(core_busy),
      .fifo_level(fifo_level), .err_timeout(err_timeout)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned last_push_cyc  = 0;
   int unsigned last_start_cyc = 0;
   int unsigned err_cyc  = 0;
   int unsigned n_starts = 0;
   int unsigned n_err    = 0;
   int unsigned core_lat = 20;
   int unsigned never_cnt = 0;
   int          lvl_model = 0;

   logic [31:0] sb_issue_din  [$];
   logic [4:0]  sb_issue_iter [$];
   logic [15:0] sb_out        [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] isqrt(input logic [31:0] v);
      longint unsigned r = 0;
      longint unsigned t;
      for (int i = 15; i >= 0; i--) begin
         t = r | (64'd1 << i);
         if (t * t <= {32'd0, v}) r = t;
      end
      return r[15:0];
   endfunction

   // Cycle-by-cycle monitor: level model, hold stability, ordering, timeout pulses
   initial begin
      logic        prev_vld = 1'b0;
      logic        prev_acc = 1'b0;
      logic [15:0] prev_data = '0;
      logic        prev_err = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            lvl_model = 0;
            prev_vld  = 1'b0;
            prev_err  = 1'b0;
         end else begin
            check("fifo_level", 32'(fifo_level), 32'(lvl_model));
            check("in_rdy", 32'(in_rdy), 32'(lvl_model != DEPTH));
            if (in_vld && in_rdy) lvl_model++;
            if (core_start) begin
               lvl_model--;
               last_start_cyc = cyc;
               n_starts++;
            end
            if (prev_vld && !prev_acc) begin
               check("hold_out_vld", 32'(out_vld), 32'd1);
               check("hold_out_data", 32'(out_data), 32'(prev_data));
            end
            if (out_vld) check("no_start_while_held", 32'(core_start), 32'd0);
            if (out_vld && out_rdy) begin
               if (sb_out.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
               else check("out_data", 32'(out_data), 32'(sb_out.pop_front()));
            end
            if (prev_err) check("err_one_cycle", 32'(err_timeout), 32'd0);
            if (err_timeout) begin
               check("timeout_latency", cyc - last_start_cyc, TIMEOUT);
               err_cyc = cyc;
               n_err++;
               if (sb_out.size() != 0) void'(sb_out.pop_front());
            end
            prev_vld  = out_vld;
            prev_acc  = out_rdy;
            prev_data = out_data;
            prev_err  = err_timeout;
         end
      end
   end

   // Behavioural sqrt core: answers isqrt(din) core_lat cycles after start
   initial begin
      logic [31:0] din;
      logic        aborted;
      forever begin
         @(negedge clk);
         if (rst_n && core_start) begin
            check("vldin_with_start", 32'(core_vldin), 32'd1);
            if (sb_issue_din.size() == 0) begin
               check("unexpected_start", core_din, 32'hFFFF_FFFF);
            end else begin
               check("core_din", core_din, sb_issue_din.pop_front());
               check("core_iter", 32'(core_iter), 32'(sb_issue_iter.pop_front()));
            end
            din = core_din;
            aborted = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (!rst_n) begin
               aborted = 1'b1;
            end else begin
               check("start_pulse_width", 32'(core_start), 32'd0);
               check("vldin_pulse_width", 32'(core_vldin), 32'd0);
               check("din_stable", core_din, din);
            end
            if (never_cnt > 0) begin
               never_cnt--;
               aborted = 1'b1;
            end
            if (!aborted) begin
               repeat (core_lat - 1) begin
                  @(posedge clk);
                  if (!rst_n) aborted = 1'b1;
               end
            end
            if (!aborted) begin
               #1;
               model_dout  = isqrt(din);
               model_ready = 1'b1;
               @(posedge clk);
               #1 model_ready = 1'b0;
               @(negedge clk);
               if (rst_n) check("out_vld_latency", 32'(out_vld), 32'd1);
            end
         end
      end
   end

   task automatic push(input logic [31:0] v, input logic [15:0] root);
      int unsigned g = 0;
      in_vld  = 1'b1;
      in_data = v;
      while (!in_rdy && g < 2000) begin
         @(posedge clk); #1;
         g++;
      end
      if (!in_rdy) begin
         check("push_wait_bound", 32'(in_rdy), 32'd1);
         in_vld = 1'b0;
         return;
      end
      @(posedge clk);
      sb_issue_din.push_back(v);
      sb_issue_iter.push_back(cfg_iter);
      sb_out.push_back(root);
      #1;
      in_vld = 1'b0;
      last_push_cyc = cyc;
   endtask

   task automatic drain();
      int unsigned g = 0;
      while ((sb_out.size() != 0 || out_vld) && g < 3000) begin
         @(posedge clk); #1;
         g++;
      end
      check("drain_done", sb_out.size(), 32'd0);
   endtask

   task automatic wait_starts(input int unsigned target, input int unsigned bound);
      int unsigned g = 0;
      while (n_starts < target && g < bound) begin
         @(posedge clk); #1;
         g++;
      end
      check("start_wait_bound", n_starts, target);
   endtask

   typedef struct {
      logic [31:0] din;
      logic [4:0]  iter;
      logic [15:0] root;
      int unsigned lat;
   } vec_t;

   initial begin
      vec_t vecs[8];
      int unsigned s0;
      int unsigned e0;
      int unsigned rel_cyc;
      int unsigned g;
      logic [31:0] t2_din  [6];
      logic [15:0] t2_root [6];

      vecs[0] = '{32'h0000_0100, 5'd16, 16'h0010, 20};
      vecs[1] = '{32'h0000_0000, 5'd16, 16'h0000, 1};
      vecs[2] = '{32'h0000_0001, 5'd8,  16'h0001, 5};
      vecs[3] = '{32'hFFFF_FFFF, 5'd31, 16'hFFFF, 40};
      vecs[4] = '{32'd15,        5'd3,  16'd3,    3};
      vecs[5] = '{32'd16,        5'd0,  16'd4,    2};
      vecs[6] = '{32'd1000000,   5'd20, 16'd1000, 10};
      vecs[7] = '{32'h4000_0000, 5'd16, 16'h8000, 7};
      t2_din  = '{32'd9, 32'd100, 32'd65535, 32'd65536, 32'd2, 32'd99};
      t2_root = '{16'd3, 16'd10,  16'd255,   16'd256,   16'd1, 16'd9};

      rst_n = 1'b0; in_vld = 1'b0; in_data = '0; cfg_iter = 5'd16;
      out_rdy = 1'b1; core_busy = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_vld", 32'(out_vld), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_core_start", 32'(core_start), 32'd0);
      check("rst_core_vldin", 32'(core_vldin), 32'd0);
      check("rst_core_din", core_din, 32'd0);
      check("rst_core_iter", 32'(core_iter), 32'd0);
      check("rst_err_timeout", 32'(err_timeout), 32'd0);
      check("rst_fifo_level", 32'(fifo_level), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_rdy", 32'(in_rdy), 32'd1);
      @(posedge clk); #1;

      // Single requests over a range of radicands and core latencies
      for (int i = 0; i < 8; i++) begin
         cfg_iter = vecs[i].iter;
         core_lat = vecs[i].lat;
         s0 = n_starts;
         push(vecs[i].din, vecs[i].root);
         wait_starts(s0 + 1, 20);
         check("issue_latency", last_start_cyc, last_push_cyc + 1);
         drain();
         check("one_start_per_req", n_starts - s0, 32'd1);
      end

      // FIFO fills while the core is busy, then drains in order
      cfg_iter = 5'd16; core_lat = 5; core_busy = 1'b1; s0 = n_starts;
      fork
         begin
            for (int i = 0; i < 6; i++) push(t2_din[i], t2_root[i]);
         end
         begin
            g = 0;
            while (fifo_level != 4 && g < 200) begin
               @(posedge clk); #1;
               g++;
            end
            @(negedge clk);
            check("full_level", 32'(fifo_level), 32'd4);
            check("full_in_rdy", 32'(in_rdy), 32'd0);
            repeat (5) @(negedge clk);
            check("busy_no_start", n_starts - s0, 32'd0);
            @(posedge clk); #1;
            core_busy = 1'b0;
         end
      join
      drain();
      check("fill_starts", n_starts - s0, 32'd6);

      // Result held by the consumer blocks the next issue
      core_lat = 3; out_rdy = 1'b0; s0 = n_starts;
      push(32'd144, 16'd12);
      push(32'd169, 16'd13);
      g = 0;
      while (!out_vld && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (10) @(negedge clk);
      check("held_out_vld", 32'(out_vld), 32'd1);
      check("held_out_data", 32'(out_data), 32'd12);
      check("hold_no_issue", n_starts - s0, 32'd1);
      @(posedge clk); #1;
      out_rdy = 1'b1;
      drain();
      check("hold_starts", n_starts - s0, 32'd2);

      // Core ignores the first request: watchdog abandons it, second is issued
      never_cnt = 1; core_lat = 4; e0 = n_err; s0 = n_starts;
      push(32'h0001_0000, 16'h0100);
      push(32'd49, 16'd7);
      g = 0;
      while (n_err == e0 && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      check("timeout_seen", n_err - e0, 32'd1);
      wait_starts(s0 + 2, 20);
      check("reissue_after_timeout", last_start_cyc, err_cyc + 1);
      drain();
      check("single_timeout", n_err - e0, 32'd1);

      // Busy core blocks issue; stray ready in IDLE is ignored
      core_lat = 6; core_busy = 1'b1; s0 = n_starts;
      push(32'd625, 16'd25);
      repeat (8) @(negedge clk);
      check("busy_holds_issue", n_starts - s0, 32'd0);
      @(posedge clk); #1;
      stray_dout  = 16'h1234;
      stray_ready = 1'b1;
      @(posedge clk); #1;
      stray_ready = 1'b0;
      @(negedge clk);
      check("stray_ready_ignored", 32'(out_vld), 32'd0);
      @(posedge clk); #1;
      core_busy = 1'b0;
      rel_cyc = cyc;
      wait_starts(s0 + 1, 20);
      check("issue_after_busy", last_start_cyc, rel_cyc + 1);
      drain();

      // Reset in WAIT with three queued entries
      core_lat = 30; s0 = n_starts;
      push(32'd400, 16'd20);
      push(32'd441, 16'd21);
      push(32'd484, 16'd22);
      push(32'd529, 16'd23);
      repeat (5) @(negedge clk);
      check("pre_reset_level", 32'(fifo_level), 32'd3);
      check("pre_reset_starts", n_starts - s0, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_vld", 32'(out_vld), 32'd0);
      check("mid_rst_core_start", 32'(core_start), 32'd0);
      check("mid_rst_core_vldin", 32'(core_vldin), 32'd0);
      check("mid_rst_core_din", core_din, 32'd0);
      check("mid_rst_core_iter", 32'(core_iter), 32'd0);
      check("mid_rst_err", 32'(err_timeout), 32'd0);
      check("mid_rst_level", 32'(fifo_level), 32'd0);
      sb_issue_din.delete();
      sb_issue_iter.delete();
      sb_out.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      core_lat = 20; s0 = n_starts;
      push(32'd196, 16'd14);
      drain();
      check("post_reset_starts", n_starts - s0, 32'd1);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running at %0t, limit 1000000", $time);
      $fatal(1, "simulation time limit reached");
   end

endmodule
